// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source and pwm_capture: the raw line in, and the measurement out.
// The slave modport is the capture block's view; the master modport is the source/consumer's view.
interface pwm_capture_if #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) ();

   logic                 pwm_in;
   logic [WIDTH-1:0]     level;
   logic [CNT_WIDTH-1:0] high_time;
   logic [CNT_WIDTH-1:0] period;
   logic                 valid;
   logic                 stuck;

   modport slave (
      input  pwm_in,
      output level,
      output high_time,
      output period,
      output valid,
      output stuck
   );

   modport master (
      output pwm_in,
      input  level,
      input  high_time,
      input  period,
      input  valid,
      input  stuck
   );

endinterface

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM line in clk cycles,
// maps the high time onto a WIDTH-bit duty level and flags a line that stops toggling.
module pwm_capture #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16,
   parameter int TIMEOUT   = 1024
) (
   input  logic           clk,
   input  logic           reset,
   pwm_capture_if.slave   bus
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_RISE = 2'd1;
   localparam logic [1:0] ST_HIGH      = 2'd2;
   localparam logic [1:0] ST_LOW       = 2'd3;

   localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] LVL_MAX_C = CNT_WIDTH'((2**WIDTH) - 1);
   localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] x);
      return (x == {CNT_WIDTH{1'b1}}) ? x : x + ONE_C;
   endfunction

   function automatic logic [WIDTH-1:0] sat_level(input logic [CNT_WIDTH-1:0] x);
      return (x > LVL_MAX_C) ? {WIDTH{1'b1}} : x[WIDTH-1:0];
   endfunction

   logic                 s1_q, s1_d;
   logic                 s2_q, s2_d;
   logic                 s3_q, s3_d;
   logic [1:0]           sync_fill_q, sync_fill_d;
   logic [1:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] hi_cnt_q, hi_cnt_d;
   logic [CNT_WIDTH-1:0] per_cnt_q, per_cnt_d;
   logic [CNT_WIDTH-1:0] hi_lat_q, hi_lat_d;
   logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
   logic [WIDTH-1:0]     level_q, level_d;
   logic [CNT_WIDTH-1:0] high_time_q, high_time_d;
   logic [CNT_WIDTH-1:0] period_q, period_d;
   logic                 valid_q, valid_d;
   logic                 stuck_q, stuck_d;

   logic rise;
   logic fall;
   logic edge_seen;
   logic timeout;

   assign rise      = s2_q & ~s3_q;
   assign fall      = ~s2_q & s3_q;
   assign edge_seen = rise | fall;
   assign timeout   = ~edge_seen & ~stuck_q & (edge_cnt_q >= TIMEOUT_C);

   always_comb begin
      s1_d        = bus.pwm_in;
      s2_d        = s1_q;
      s3_d        = s2_q;
      // The reset value of the synchroniser is not a sample of the line; wait until s2 holds one.
      sync_fill_d = (sync_fill_q == 2'd2) ? sync_fill_q : sync_fill_q + 2'd1;

      state_d     = state_q;
      hi_cnt_d    = hi_cnt_q;
      per_cnt_d   = per_cnt_q;
      hi_lat_d    = hi_lat_q;
      level_d     = level_q;
      high_time_d = high_time_q;
      period_d    = period_q;
      valid_d     = 1'b0;
      stuck_d     = edge_seen ? 1'b0 : stuck_q;
      edge_cnt_d  = edge_seen ? '0 : sat_inc(edge_cnt_q);

      if (timeout) begin
         stuck_d     = 1'b1;
         valid_d     = 1'b1;
         high_time_d = '0;
         period_d    = '0;
         level_d     = {WIDTH{s2_q}};
         hi_cnt_d    = '0;
         per_cnt_d   = '0;
         state_d     = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Leaving only once the line reads low drops a high phase already in progress.
               if (sync_fill_q == 2'd2 && !s2_q) begin
                  state_d = ST_WAIT_RISE;
               end
            end
            ST_WAIT_RISE: begin
               if (rise) begin
                  hi_cnt_d  = ONE_C;
                  per_cnt_d = ONE_C;
                  state_d   = ST_HIGH;
               end
            end
            ST_HIGH: begin
               per_cnt_d = sat_inc(per_cnt_q);
               if (fall) begin
                  hi_lat_d = hi_cnt_q;
                  state_d  = ST_LOW;
               end else begin
                  hi_cnt_d = sat_inc(hi_cnt_q);
               end
            end
            default: begin
               if (rise) begin
                  period_d    = per_cnt_q;
                  high_time_d = hi_lat_q;
                  level_d     = sat_level(hi_lat_q);
                  valid_d     = 1'b1;
                  hi_cnt_d    = ONE_C;
                  per_cnt_d   = ONE_C;
                  state_d     = ST_HIGH;
               end else begin
                  per_cnt_d = sat_inc(per_cnt_q);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         s3_q        <= 1'b0;
         sync_fill_q <= 2'd0;
         state_q     <= ST_IDLE;
         hi_cnt_q    <= '0;
         per_cnt_q   <= '0;
         hi_lat_q    <= '0;
         edge_cnt_q  <= '0;
         level_q     <= '0;
         high_time_q <= '0;
         period_q    <= '0;
         valid_q     <= 1'b0;
         stuck_q     <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         s3_q        <= s3_d;
         sync_fill_q <= sync_fill_d;
         state_q     <= state_d;
         hi_cnt_q    <= hi_cnt_d;
         per_cnt_q   <= per_cnt_d;
         hi_lat_q    <= hi_lat_d;
         edge_cnt_q  <= edge_cnt_d;
         level_q     <= level_d;
         high_time_q <= high_time_d;
         period_q    <= period_d;
         valid_q     <= valid_d;
         stuck_q     <= stuck_d;
      end
   end

   assign bus.level     = level_q;
   assign bus.high_time = high_time_q;
   assign bus.period    = period_q;
   assign bus.valid     = valid_q;
   assign bus.stuck     = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: known PWM patterns, stuck-line timeouts and resets
// at awkward moments, each checked against hand-computed measurements.
module tb_pwm_capture;

   logic clk;
   logic reset;
   int   cyc;
   int   n_cmp;
   int   n_err;
   int   vcount;
   int   vq[$];
   int   rq[$];

   pwm_capture_if #(.WIDTH(8), .CNT_WIDTH(16)) bus ();

   pwm_capture #(.WIDTH(8), .CNT_WIDTH(16), .TIMEOUT(1024)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial vcount = 0;
   always @(negedge clk) begin
      if (bus.valid) begin
         vcount = vcount + 1;
         vq.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic v);
      @(posedge clk);
      #1;
      bus.pwm_in = v;
   endtask

   task automatic hold(input logic v, input int n);
      for (int i = 0; i < n; i++) step(v);
   endtask

   task automatic pulses(input int h, input int l, input int n);
      for (int p = 0; p < n; p++) begin
         step(1'b1);
         rq.push_back(cyc);
         hold(1'b1, h - 1);
         hold(1'b0, l);
      end
   endtask

   task automatic check_out(input string tag, input int lvl, input int ht, input int per);
      @(negedge clk);
      check_eq({tag, ".level"}, 32'(bus.level), lvl);
      check_eq({tag, ".high_time"}, 32'(bus.high_time), ht);
      check_eq({tag, ".period"}, 32'(bus.period), per);
   endtask

   initial begin
      int v0;
      int r0;
      n_cmp = 0;
      n_err = 0;
      bus.pwm_in = 1'b0;
      reset = 1'b1;
      hold(1'b0, 3);

      // reset state
      @(negedge clk);
      check_eq("rst.level", 32'(bus.level), 0);
      check_eq("rst.high_time", 32'(bus.high_time), 0);
      check_eq("rst.period", 32'(bus.period), 0);
      check_eq("rst.valid", 32'(bus.valid), 0);
      check_eq("rst.stuck", 32'(bus.stuck), 0);
      reset = 1'b0;
      hold(1'b0, 10);

      // 64 high / 192 low
      v0 = vq.size();
      r0 = rq.size();
      pulses(64, 192, 4);
      check_eq("t1.count", 32'(vq.size() - v0), 3);
      check_out("t1", 64, 64, 256);
      check_eq("t1.latency", 32'(vq[v0] - rq[r0 + 1]), 3);
      check_eq("t1.interval", 32'(vq[vq.size() - 1] - vq[vq.size() - 2]), 256);

      // stuck low, stuck high, restart
      v0 = vcount;
      hold(1'b0, 1040);
      check_eq("t4lo.count", 32'(vcount - v0), 1);
      check_eq("t4lo.stuck", 32'(bus.stuck), 1);
      check_out("t4lo", 0, 0, 0);
      v0 = vcount;
      hold(1'b1, 10);
      check_eq("t4hi.stuck_clear", 32'(bus.stuck), 0);
      hold(1'b1, 1090);
      check_eq("t4hi.count", 32'(vcount - v0), 1);
      check_eq("t4hi.stuck", 32'(bus.stuck), 1);
      check_out("t4hi", 255, 0, 0);
      v0 = vcount;
      hold(1'b0, 50);
      check_eq("t4re.stuck_clear", 32'(bus.stuck), 0);
      check_eq("t4re.no_early", 32'(vcount - v0), 0);
      pulses(64, 192, 2);
      check_eq("t4re.count", 32'(vcount - v0), 1);
      check_out("t4re", 64, 64, 256);

      // 255/1, then 300/100 saturating the level
      v0 = vcount;
      pulses(255, 1, 3);
      check_eq("t2a.count", 32'(vcount - v0), 3);
      check_out("t2a", 255, 255, 256);
      v0 = vcount;
      pulses(300, 100, 3);
      check_eq("t2b.count", 32'(vcount - v0), 3);
      check_out("t2b", 255, 300, 400);

      // single-cycle high pulse
      v0 = vcount;
      pulses(1, 9, 4);
      check_eq("t3.count", 32'(vcount - v0), 4);
      check_out("t3", 1, 1, 10);

      // reset while high, released mid-high phase
      hold(1'b1, 20);
      reset = 1'b1;
      hold(1'b1, 3);
      reset = 1'b0;
      check_out("t5rst", 0, 0, 0);
      v0 = vcount;
      hold(1'b1, 40);
      hold(1'b0, 100);
      check_eq("t5.no_partial", 32'(vcount - v0), 0);
      pulses(80, 176, 2);
      check_eq("t5.count", 32'(vcount - v0), 1);
      check_out("t5", 80, 80, 256);

      // one-cycle reset in the low phase
      hold(1'b1, 64);
      hold(1'b0, 100);
      check_eq("t6.pre_level", 32'(bus.level), 80);
      step(1'b0);
      reset = 1'b1;
      step(1'b0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("t6rst.level", 32'(bus.level), 0);
      check_eq("t6rst.high_time", 32'(bus.high_time), 0);
      check_eq("t6rst.period", 32'(bus.period), 0);
      check_eq("t6rst.valid", 32'(bus.valid), 0);
      v0 = vcount;
      hold(1'b0, 90);
      pulses(64, 192, 1);
      check_eq("t6.no_first", 32'(vcount - v0), 0);
      pulses(64, 192, 1);
      check_eq("t6.count", 32'(vcount - v0), 1);
      check_out("t6", 64, 64, 256);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
